// File: rtl/hc595_serial_driver.sv
// Parallel-to-serial front end for a 74HC595 chain: accepts a word over load/ready,
// shifts it MSB-first on ser/srclk, then pulses rclk to update the storage register.
module hc595_serial_driver #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             ser,
    output logic             srclk,
    output logic             rclk,
    output logic             done
);

    localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BCW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t           state;
    logic [DCW-1:0]   div_cnt;
    logic [BCW-1:0]   bit_cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shl;
    logic             div_last;

    assign div_last = (div_cnt == DCW'(DIV - 1));
    assign sreg_shl = sreg << 1;

    // Every phase (srclk low, srclk high, rclk high) lasts exactly DIV cycles;
    // ser only changes together with srclk falling, so it brackets each rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            ready   <= 1'b1;
            ser     <= 1'b0;
            srclk   <= 1'b0;
            rclk    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load && ready) begin
                        sreg    <= din;
                        bit_cnt <= BCW'(WIDTH);
                        div_cnt <= '0;
                        ser     <= din[WIDTH-1];
                        ready   <= 1'b0;
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        srclk   <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        srclk   <= 1'b0;
                        sreg    <= sreg_shl;
                        bit_cnt <= bit_cnt - BCW'(1);
                        if (bit_cnt == BCW'(1)) begin
                            ser   <= 1'b0;
                            rclk  <= 1'b1;
                            state <= LATCH;
                        end else begin
                            ser   <= sreg_shl[WIDTH-1];
                            state <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end
                LATCH: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        rclk    <= 1'b0;
                        ready   <= 1'b1;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
